paddle_controller: RTL and testbench
====================================

# paddle_controller

Generates the vertical position of one player paddle from two raw push-button inputs. Its `y_pad` output drives the paddle-position input of the ball controller and the paddle renderer. The block synchronises and debounces the buttons, then steps the paddle once per `timing_tick`. Speed ramps from slow to fast while a button is held, and the position is clamped to the visible area. One instance is built per player.

## Interface
- `PAD_HEIGHT`, 72, paddle height in pixels.
- `DEBOUNCE_CYCLES`, 500_000, number of consecutive stable clocks required to accept a button level.
- `V_SLOW`, 2, step size in pixels per tick in SLOW.
- `V_FAST`, 4, step size in pixels per tick in FAST.
- `RAMP_TICKS`, 16, number of ticks spent in SLOW before entering FAST.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `timing_tick`  in  1  one-clk pulse, the same tick the ball controller uses.
- `btn_up`  in  1  raw button, asynchronous to `clk`, active-high.
- `btn_down`  in  1  raw button, asynchronous to `clk`, active-high.
- `y_pad`  out  10  top edge of the paddle, in pixels.
- `moving`  out  1  high while the FSM is in SLOW or FAST.

## Operation
- **Input path:** each button passes through a 2-FF synchroniser and then a debouncer. The debounced level changes only after the synchronised level has been stable for `DEBOUNCE_CYCLES` consecutive clocks. Any change restarts the counter.
- **Direction decode from debounced levels:**
  - up only: UP.
  - down only: DOWN.
  - neither, or both: NONE.
- **FSM states:** IDLE, SLOW, FAST. It holds a direction register `dir` and a tick counter `ramp_cnt` sized clog2(`RAMP_TICKS`+1).
- **IDLE:**
  - On decode UP or DOWN, go to SLOW, latch `dir`, clear `ramp_cnt`.
  - No position change on the cycle of entry.
- **SLOW:**
  - On each `timing_tick`, step by `V_SLOW` in `dir` and increment `ramp_cnt`.
  - When `ramp_cnt` reaches `RAMP_TICKS`, go to FAST.
- **FAST:** on each `timing_tick`, step by `V_FAST`.
- **SLOW/FAST, decode NONE:** go to IDLE immediately. Takes priority over a same-cycle tick, so no step is taken.
- **SLOW/FAST, decode opposite to `dir`:** go to SLOW with the new `dir` and clear `ramp_cnt`. No step on that cycle.
- **Arithmetic:**
  - The next position is computed in 11 bits: `{1'b0,y_pad}` ± step.
  - Underflow (bit 10 set, or result greater than `PAD_Y_MAX` when moving up) clamps to 0.
  - A result greater than `PAD_Y_MAX` when moving down clamps to `PAD_Y_MAX`.
- `PAD_Y_MAX` = `VER_PIXELS` − `PAD_HEIGHT` (696 for `VER_PIXELS` = 768).
- Reaching a clamp limit does not change state. The FSM remains in SLOW/FAST and further ticks hold the value.

## Timing
- **Reset values (asynchronous, all flops):**
  - `y_pad` = (`VER_PIXELS` − `PAD_HEIGHT`)/2 = 348.
  - `moving` = 0; state IDLE; `ramp_cnt` = 0.
  - Synchroniser and debouncer flops = 0.
- **Reset mid-operation:** outputs return to reset values immediately, not on the next clock edge.
- **Button-to-decode latency:** 2 clocks of synchroniser + `DEBOUNCE_CYCLES` + 1 clock for the debounce register.
- **Step latency:** `y_pad` is registered and changes on the clock edge that samples `timing_tick` = 1. It is stable for all other cycles, which lets the ball controller sample it at any time.
- `moving` is a registered decode of state and is valid the cycle after the state changes.
- **`timing_tick` high for more than one cycle:** each high cycle counts as a separate tick.

## Structure
- **`vga_pkg`:**
  - Add `PAD_HEIGHT_DEF` and `PAD_Y_MAX` here.
  - `VER_PIXELS` already lives here.
  - The `paddle_state_t` enum (IDLE/SLOW/FAST) also belongs here, so the renderer and debug logic can share it.
- **Sub-module `button_debounce`:** contains the synchroniser and debouncer, parameterised by `DEBOUNCE_CYCLES`, and is instantiated twice. Decode, FSM and position datapath stay in `paddle_controller`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `V_SLOW`=2, `V_FAST`=4, `RAMP_TICKS`=16, and a tick every 10 clocks.
- **Reset:** release `rst_n` → `y_pad`=348, `moving`=0. Assert `rst_n` low while in FAST at `y_pad`=500 → 348 in the same cycle, without waiting for a clock edge.
- **Ramp:** hold `btn_down` → 16 ticks of +2 bring `y_pad` to 380 with state moving to FAST. The next 3 ticks are +4, giving 384, 388, 392.
- **Clamp:**
  - Down: FAST down from 694 → 696, then stays at 696 over 5 more ticks with `moving`=1.
  - Up: SLOW up from 1 → 0, then holds at 0.
- **Glitch reject and both-pressed:**
  - A 3-clock `btn_up` pulse → no movement, `moving`=0.
  - Both buttons held → IDLE, `y_pad` constant.
  - Then releasing `btn_down` → SLOW up, first tick −2.
- **Reversal and release:**
  - In FAST down, switch to `btn_up` → SLOW, first tick −2, `ramp_cnt` restarts.
  - Release on a tick cycle → no step, IDLE.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA geometry constants and paddle FSM types used by the game logic,
// the paddle renderer and debug taps.
package vga_pkg;

    localparam int unsigned VER_PIXELS     = 768;
    localparam int unsigned PAD_HEIGHT_DEF = 72;
    localparam int unsigned PAD_Y_MAX      = VER_PIXELS - PAD_HEIGHT_DEF;

    typedef enum logic [1:0] {
        StIdle,
        StSlow,
        StFast
    } paddle_state_t;

    typedef enum logic [1:0] {
        ReqNone,
        ReqUp,
        ReqDown
    } paddle_req_t;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a debouncer: the output level follows the
// synchronised button only after it has held a new value for DEBOUNCE_CYCLES clocks.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            // Counter only runs while the synchronised value disagrees with the accepted level.
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/paddle_controller.sv
// Paddle position generator: debounced up/down buttons drive a slow/fast ramping
// stepper that moves y_pad once per timing_tick, clamped to the visible area.
module paddle_controller
    import vga_pkg::*;
#(
    parameter int unsigned PAD_HEIGHT      = PAD_HEIGHT_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned V_SLOW          = 2,
    parameter int unsigned V_FAST          = 4,
    parameter int unsigned RAMP_TICKS      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       timing_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [9:0] y_pad,
    output logic       moving
);

    localparam int unsigned RCW     = $clog2(RAMP_TICKS + 1);
    localparam logic [10:0] Y_MAX   = 11'(VER_PIXELS - PAD_HEIGHT);
    localparam logic [9:0]  Y_RESET = 10'((VER_PIXELS - PAD_HEIGHT) / 2);

    logic           up_lvl;
    logic           down_lvl;
    paddle_req_t    req;
    paddle_state_t  state;
    logic           dir_down;
    logic [RCW-1:0] ramp_cnt;
    logic [10:0]    step;
    logic [10:0]    sum;
    logic [9:0]     y_next;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_up (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_up),
        .level(up_lvl)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_down (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_down),
        .level(down_lvl)
    );

    always_comb begin
        req = ReqNone;
        if (up_lvl && !down_lvl) begin
            req = ReqUp;
        end else if (down_lvl && !up_lvl) begin
            req = ReqDown;
        end
    end

    // Moving up past zero wraps into bit 10 or above Y_MAX; either way it pins to 0.
    always_comb begin
        step = (state == StFast) ? 11'(V_FAST) : 11'(V_SLOW);
        sum  = dir_down ? ({1'b0, y_pad} + step) : ({1'b0, y_pad} - step);
        if (!dir_down && (sum[10] || sum > Y_MAX)) begin
            y_next = '0;
        end else if (dir_down && sum > Y_MAX) begin
            y_next = Y_MAX[9:0];
        end else begin
            y_next = sum[9:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            dir_down <= 1'b0;
            ramp_cnt <= '0;
            y_pad    <= Y_RESET;
            moving   <= 1'b0;
        end else begin
            moving <= (state != StIdle);
            unique case (state)
                StIdle: begin
                    if (req != ReqNone) begin
                        state    <= StSlow;
                        dir_down <= (req == ReqDown);
                        ramp_cnt <= '0;
                    end
                end
                StSlow, StFast: begin
                    if (req == ReqNone) begin
                        state <= StIdle;
                    end else if ((req == ReqDown) != dir_down) begin
                        state    <= StSlow;
                        dir_down <= (req == ReqDown);
                        ramp_cnt <= '0;
                    end else if (timing_tick) begin
                        y_pad <= y_next;
                        if (state == StSlow) begin
                            ramp_cnt <= ramp_cnt + 1'b1;
                            if (ramp_cnt == RCW'(RAMP_TICKS - 1)) begin
                                state <= StFast;
                            end
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_paddle_controller.sv
// Scoreboard bench for paddle_controller: each issued tick queues the expected
// paddle position and moving flag; a monitor checks them after the sampling edge.
`timescale 1ns/1ps
module tb_paddle_controller;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic       timing_tick = 1'b0;
    logic       btn_up      = 1'b0;
    logic       btn_down    = 1'b0;
    logic [9:0] y_pad;
    logic       moving;

    typedef struct {
        int y;
        int mv;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tick_idx = 0;
    logic tick_q   = 1'b0;

    paddle_controller #(
        .PAD_HEIGHT     (72),
        .DEBOUNCE_CYCLES(4),
        .V_SLOW         (2),
        .V_FAST         (4),
        .RAMP_TICKS     (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .timing_tick(timing_tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .y_pad      (y_pad),
        .moving     (moving)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: y_pad/moving are compared half a cycle after every edge that sampled a tick.
    always @(posedge clk) tick_q <= timing_tick;

    always @(negedge clk) begin
        if (tick_q) begin
            exp_t e;
            tick_idx++;
            if (exp_q.size() == 0) begin
                check($sformatf("tick %0d has no expectation", tick_idx), 1, 0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("tick %0d y_pad", tick_idx), int'(y_pad), e.y);
                check($sformatf("tick %0d moving", tick_idx), int'(moving), e.mv);
            end
        end
    end

    task automatic push_exp(input int y, input int mv);
        exp_t e;
        e.y  = y;
        e.mv = mv;
        exp_q.push_back(e);
    endtask

    // One tick every 10 clocks; returns one time unit after the edge that sampled it.
    task automatic tick(input int y, input int mv);
        repeat (9) @(posedge clk);
        #1 timing_tick = 1'b1;
        push_exp(y, mv);
        @(posedge clk);
        #1 timing_tick = 1'b0;
    endtask

    task automatic settle();
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check("reset y_pad", int'(y_pad), 348);
        check("reset moving", int'(moving), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(348, 0);

        // Three-clock glitch on btn_up must be rejected.
        btn_up = 1'b1;
        repeat (3) @(posedge clk);
        #1 btn_up = 1'b0;
        settle();
        tick(348, 0);

        // Ramp: 16 slow ticks down, then fast steps up to 500.
        btn_down = 1'b1;
        settle();
        for (int k = 1; k <= 16; k++) tick(348 + 2 * k, 1);
        for (int k = 1; k <= 30; k++) tick(380 + 4 * k, 1);

        // Asynchronous reset in FAST at 500, observed before any clock edge.
        btn_down = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async reset y_pad", int'(y_pad), 348);
        check("async reset moving", int'(moving), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(348, 0);

        // Both pressed decodes to NONE; releasing down leaves an up request.
        btn_up   = 1'b1;
        btn_down = 1'b1;
        settle();
        tick(348, 0);
        tick(348, 0);
        btn_down = 1'b0;
        settle();
        tick(346, 1);
        btn_up = 1'b0;
        settle();
        tick(346, 0);

        // Down clamp: 346 -> 378 slow, fast to 694, then pinned at 696.
        btn_down = 1'b1;
        settle();
        for (int k = 1; k <= 16; k++) tick(346 + 2 * k, 1);
        for (int k = 1; k <= 79; k++) tick(378 + 4 * k, 1);
        for (int k = 0; k < 6; k++) tick(696, 1);

        // Reversal from FAST down restarts the slow ramp going up.
        btn_down = 1'b0;
        btn_up   = 1'b1;
        settle();
        for (int k = 1; k <= 16; k++) tick(696 - 2 * k, 1);
        tick(660, 1);

        // Release timed so the decode drops to NONE on the same cycle as a tick.
        btn_up = 1'b0;
        repeat (6) @(posedge clk);
        #1 timing_tick = 1'b1;
        push_exp(660, 1);
        @(posedge clk);
        #1 timing_tick = 1'b0;
        settle();
        tick(660, 0);

        // Up clamp: move to 662, then slow/fast up to 2, underflow pins to 0.
        btn_down = 1'b1;
        settle();
        tick(662, 1);
        btn_down = 1'b0;
        settle();
        tick(662, 0);
        btn_up = 1'b1;
        settle();
        for (int k = 1; k <= 16; k++) tick(662 - 2 * k, 1);
        for (int k = 1; k <= 157; k++) tick(630 - 4 * k, 1);
        for (int k = 0; k < 3; k++) tick(0, 1);
        btn_up = 1'b0;
        settle();
        tick(0, 0);

        // Slow up from 0 holds at 0.
        btn_up = 1'b1;
        settle();
        tick(0, 1);
        tick(0, 1);
        btn_up = 1'b0;
        settle();

        repeat (3) @(posedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
